// File: rtl/life_pkg.sv
// Shared definitions for the Life arena: host sequencer states, row-select
// width and the default row type.
package life_pkg;

    localparam int ROW_SEL_W           = 8;
    localparam int ARENA_WIDTH_DEFAULT = 10;

    typedef logic [ARENA_WIDTH_DEFAULT-1:0] row_t;

    typedef enum logic [1:0] {
        HOST_IDLE  = 2'd0,
        HOST_CLEAR = 2'd1,
        HOST_LOAD  = 2'd2,
        HOST_SCAN  = 2'd3
    } host_state_t;

    // Highest index of a range of `count` entries, at row-select width.
    function automatic logic [ROW_SEL_W-1:0] last_index(input int count);
        return ROW_SEL_W'(count - 1);
    endfunction

endpackage

// File: rtl/arena_store_if.sv
// Solver and host-side signals of the arena store. The master drives
// requests and row data; the store is the slave.
interface arena_store_if #(
    parameter int ARENA_WIDTH = 10
);
    import life_pkg::*;

    logic [ROW_SEL_W-1:0]   arena_row_select;
    logic [ARENA_WIDTH-1:0] arena_columns;
    logic [ARENA_WIDTH-1:0] arena_columns_new;
    logic                   arena_columns_write;
    logic                   solver_ready;
    logic                   clear_start;
    logic                   load_start;
    logic                   load_valid;
    logic                   load_cell;
    logic                   load_ready;
    logic                   scan_start;
    logic                   scan_valid;
    logic                   scan_ready;
    logic [ROW_SEL_W-1:0]   scan_row_index;
    logic [ARENA_WIDTH-1:0] scan_row;
    logic                   host_busy;
    logic                   host_done;

    modport master (
        output arena_row_select, arena_columns_new, arena_columns_write,
               solver_ready, clear_start, load_start, load_valid, load_cell,
               scan_start, scan_ready,
        input  arena_columns, load_ready, scan_valid, scan_row_index,
               scan_row, host_busy, host_done
    );

    modport slave (
        input  arena_row_select, arena_columns_new, arena_columns_write,
               solver_ready, clear_start, load_start, load_valid, load_cell,
               scan_start, scan_ready,
        output arena_columns, load_ready, scan_valid, scan_row_index,
               scan_row, host_busy, host_done
    );

endinterface

// File: rtl/arena_row_assembler.sv
// Serial-to-row converter for the LOAD sweep: cells arrive column 0 first and
// a row-complete strobe fires on the cell that fills the last column.
module arena_row_assembler
    import life_pkg::*;
#(
    parameter int ARENA_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_accept,
    input  logic                   i_cell,
    output logic [ARENA_WIDTH-1:0] o_row,
    output logic                   o_row_done
);

    localparam logic [ROW_SEL_W-1:0] LAST_COL = last_index(ARENA_WIDTH);

    logic [ARENA_WIDTH-1:0] r_shift;
    logic [ROW_SEL_W-1:0]   r_col;
    logic [ARENA_WIDTH-1:0] w_row;

    // The completed row includes the cell being accepted this cycle, so the
    // store can write it on the same edge.
    always_comb begin
        w_row = r_shift;
        for (int i = 0; i < ARENA_WIDTH; i++) begin
            if (r_col == ROW_SEL_W'(i)) begin
                w_row[i] = i_cell;
            end
        end
    end

    assign o_row      = w_row;
    assign o_row_done = i_accept && (r_col == LAST_COL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_col   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_col   <= '0;
        end else if (i_accept) begin
            if (r_col == LAST_COL) begin
                r_shift <= '0;
                r_col   <= '0;
            end else begin
                r_shift <= w_row;
                r_col   <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arena_store.sv
// Row-organised Life arena with a combinational solver port and a host
// sequencer offering clear, serial load and row scan-out.
module arena_store
    import life_pkg::*;
#(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10
) (
    input logic          clk,
    input logic          reset,
    arena_store_if.slave bus
);

    localparam logic [ROW_SEL_W-1:0] LAST_ROW = last_index(ARENA_HEIGHT);

    host_state_t            r_state;
    host_state_t            w_state_next;
    logic [ROW_SEL_W-1:0]   r_ptr;
    logic [ROW_SEL_W-1:0]   w_ptr_next;
    logic [ARENA_WIDTH-1:0] r_arena [ARENA_HEIGHT];
    logic [ARENA_WIDTH-1:0] r_scan_row;
    logic [ROW_SEL_W-1:0]   r_scan_index;
    logic                   r_scan_valid;
    logic                   r_host_done;

    logic                   w_sel_valid;
    logic                   w_solver_we;
    logic                   w_collision;
    logic                   w_host_we;
    logic [ARENA_WIDTH-1:0] w_host_data;
    logic                   w_done;
    logic                   w_scan_load;
    logic                   w_scan_valid_next;
    logic                   w_asm_clear;
    logic                   w_asm_accept;
    logic                   w_load_ready;
    logic                   w_row_done;
    logic [ARENA_WIDTH-1:0] w_asm_row;
    logic [ARENA_WIDTH-1:0] w_sel_row;
    logic [ARENA_WIDTH-1:0] w_ptr_next_row;

    assign w_sel_valid = bus.arena_row_select < ROW_SEL_W'(ARENA_HEIGHT);
    assign w_solver_we = bus.arena_columns_write && w_sel_valid;
    assign w_collision = w_solver_we && (bus.arena_row_select == r_ptr);

    // Row read muxes: an out-of-range select matches no row and reads zero.
    always_comb begin
        w_sel_row      = '0;
        w_ptr_next_row = '0;
        for (int i = 0; i < ARENA_HEIGHT; i++) begin
            if (bus.arena_row_select == ROW_SEL_W'(i)) begin
                w_sel_row = r_arena[i];
            end
            if (w_ptr_next == ROW_SEL_W'(i)) begin
                w_ptr_next_row = r_arena[i];
            end
        end
    end

    arena_row_assembler #(
        .ARENA_WIDTH (ARENA_WIDTH)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_asm_clear),
        .i_accept   (w_asm_accept),
        .i_cell     (bus.load_cell),
        .o_row      (w_asm_row),
        .o_row_done (w_row_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HOST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Host sequencer. A solver write to the row CLEAR is about to zero takes
    // precedence and holds the pointer; LOAD avoids collisions entirely by
    // refusing cells whenever the solver writes.
    always_comb begin
        w_state_next      = r_state;
        w_ptr_next        = r_ptr;
        w_host_we         = 1'b0;
        w_host_data       = '0;
        w_done            = 1'b0;
        w_scan_load       = 1'b0;
        w_scan_valid_next = r_scan_valid;
        w_asm_clear       = 1'b0;
        w_asm_accept      = 1'b0;
        w_load_ready      = 1'b0;
        case (r_state)
            HOST_IDLE: begin
                if (bus.solver_ready) begin
                    if (bus.clear_start) begin
                        w_state_next = HOST_CLEAR;
                        w_ptr_next   = '0;
                    end else if (bus.load_start) begin
                        w_state_next = HOST_LOAD;
                        w_ptr_next   = '0;
                        w_asm_clear  = 1'b1;
                    end else if (bus.scan_start) begin
                        w_state_next      = HOST_SCAN;
                        w_ptr_next        = '0;
                        w_scan_load       = 1'b1;
                        w_scan_valid_next = 1'b1;
                    end
                end
            end
            HOST_CLEAR: begin
                if (!w_collision) begin
                    w_host_we = 1'b1;
                    if (r_ptr == LAST_ROW) begin
                        w_state_next = HOST_IDLE;
                        w_done       = 1'b1;
                    end else begin
                        w_ptr_next = r_ptr + 1'b1;
                    end
                end
            end
            HOST_LOAD: begin
                w_load_ready = !bus.arena_columns_write;
                w_asm_accept = bus.load_valid && w_load_ready;
                if (w_row_done) begin
                    w_host_we   = 1'b1;
                    w_host_data = w_asm_row;
                    if (r_ptr == LAST_ROW) begin
                        w_state_next = HOST_IDLE;
                        w_done       = 1'b1;
                    end else begin
                        w_ptr_next = r_ptr + 1'b1;
                    end
                end
            end
            HOST_SCAN: begin
                if (bus.scan_ready) begin
                    if (r_ptr == LAST_ROW) begin
                        w_state_next      = HOST_IDLE;
                        w_scan_valid_next = 1'b0;
                        w_done            = 1'b1;
                    end else begin
                        w_ptr_next  = r_ptr + 1'b1;
                        w_scan_load = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = HOST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_scan_row   <= '0;
            r_scan_index <= '0;
            r_scan_valid <= 1'b0;
            r_host_done  <= 1'b0;
        end else begin
            r_ptr        <= w_ptr_next;
            r_scan_valid <= w_scan_valid_next;
            r_host_done  <= w_done;
            if (w_scan_load) begin
                r_scan_row   <= w_ptr_next_row;
                r_scan_index <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARENA_HEIGHT; i++) begin
                r_arena[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ARENA_HEIGHT; i++) begin
                if (w_solver_we && (bus.arena_row_select == ROW_SEL_W'(i))) begin
                    r_arena[i] <= bus.arena_columns_new;
                end else if (w_host_we && (r_ptr == ROW_SEL_W'(i))) begin
                    r_arena[i] <= w_host_data;
                end
            end
        end
    end

    assign bus.arena_columns  = w_sel_row;
    assign bus.load_ready     = w_load_ready;
    assign bus.scan_valid     = r_scan_valid;
    assign bus.scan_row_index = r_scan_index;
    assign bus.scan_row       = r_scan_row;
    assign bus.host_busy      = (r_state != HOST_IDLE);
    assign bus.host_done      = r_host_done;

endmodule

// File: doc/arena_store.md
# arena_store

Row-organised storage for the Life arena and the memory-side responder of the solver's arena interface. The solver selects a row and reads its cells combinationally, and writes a whole new row in one cycle. A host-side sequencer shares the same storage. It provides a clear sweep, a serial row-major load, and a row-by-row scan-out for the display. Host operations are gated by the solver's `ready`.

## Interface
- `ARENA_WIDTH`, default 10: cells per row, 1..255.
- `ARENA_HEIGHT`, default 10: rows, 1..255.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `arena_row_select`  in  8  solver row index.
- `arena_columns`  out  ARENA_WIDTH  selected row contents, combinational.
- `arena_columns_new`  in  ARENA_WIDTH  row write data.
- `arena_columns_write`  in  1  write strobe.
- `solver_ready`  in  1  solver idle; host operations may start only while high.
- `clear_start`  in  1  pulse: zero the whole arena.
- `load_start`  in  1  pulse: begin serial load at row 0, column 0.
- `load_valid`  in  1  `load_cell` valid.
- `load_cell`  in  1  next cell, row-major, column 0 first.
- `load_ready`  out  1  cell accepted when `load_valid & load_ready`.
- `scan_start`  in  1  pulse: stream all rows out.
- `scan_valid`  out  1  scan row valid.
- `scan_ready`  in  1  consumer accepts row.
- `scan_row_index`  out  8  index of `scan_row`.
- `scan_row`  out  ARENA_WIDTH  row data.
- `host_busy`  out  1  high in any state other than IDLE.
- `host_done`  out  1  one-cycle pulse when CLEAR, LOAD or SCAN completes.

## Operation
- Storage is ARENA_HEIGHT × ARENA_WIDTH flops. All cells reset to 0.
- Solver port:
  - `arena_columns` = row[`arena_row_select`].
  - If the select is ≥ ARENA_HEIGHT, `arena_columns` = 0 and writes are ignored.
  - Solver writes are accepted in any state.
- FSM states are IDLE, CLEAR, LOAD, SCAN.
- In IDLE, a start pulse is honoured only if `solver_ready` = 1. Otherwise the pulse is dropped.
- Start priority: clear > load > scan. Start pulses outside IDLE are ignored.
- CLEAR:
  - Writes zero to row `ptr`, one row per cycle, with `ptr` running 0..H-1.
  - After the row H-1 write, returns to IDLE and pulses `host_done`.
- LOAD:
  - `load_ready` = 1 except on a cycle where the solver writes.
  - Each accepted cell shifts into the assembly register at column `col`.
  - On column W-1 the assembled row is written to row `ptr`, `col` returns to 0 and `ptr` increments.
  - After row H-1 is written, returns to IDLE and pulses `host_done`.
- SCAN:
  - `scan_row` and `scan_row_index` are registered from row `ptr`.
  - `scan_valid` holds with stable data until `scan_ready`.
  - After the H-1 handshake, returns to IDLE and pulses `host_done`.
- Host/solver collision (same row, same cycle): the solver write wins and the host write stalls one cycle. In CLEAR, `ptr` does not advance that cycle.
- Counters: `ptr` is 8-bit and `col` is 8-bit, compared against H-1 and W-1. They never wrap past those limits.

## Timing
- Reset values:
  - `load_ready`, `scan_valid`, `host_busy`, `host_done` = 0.
  - `scan_row_index` = 0, `scan_row` = 0.
  - FSM = IDLE, `ptr` = `col` = 0.
- `arena_columns` has zero cycles of latency from `arena_row_select`.
- Writes are visible on `arena_columns` the cycle after the strobe edge.
- `host_busy` rises on the edge after an accepted start.
- CLEAR takes exactly H cycles without collisions. `host_done` is in cycle H+1.
- LOAD with continuous `load_valid`: row r is visible W cycles after its first cell is accepted.
- SCAN: first `scan_valid` 1 cycle after start. With `scan_ready` held high, throughput is one row per cycle.
- Reset mid-operation aborts to IDLE and zeros the arena. A partial row in the assembly register is discarded.
- `solver_ready` falling mid-operation does not abort. The controller is responsible for not starting the solver while `host_busy` is high.

## Structure
- Shared package `life_pkg`:
  - host FSM state encoding;
  - `ROW_SEL_W` = 8;
  - row type for `ARENA_WIDTH`.
- Sub-module `arena_row_assembler`: serial-to-row shift register with column counter and row-complete strobe, used by LOAD.
- The FSM, pointer and storage array live in the top level.

## Test plan
- Reset, then `clear_start` with `solver_ready` = 1 → `host_busy` for 10 cycles, `host_done` on cycle 11, all rows read 0 via the solver port.
- `load_start`, then 100 cells (row r = `10'b1 << r`) → `host_done`; `arena_row_select` = 3 gives `arena_columns` = `10'h008`.
- `scan_start` with `scan_ready` toggling 1,0,1,… → indices 0..9 each delivered once in order, data stable while stalled, `host_done` after index 9.
- Solver writes row 5 = `10'h3FF` during LOAD → `load_ready` low that cycle; the final arena holds the solver value unless the load overwrites row 5 afterwards.
- Start pulse with `solver_ready` = 0 → no state change. `arena_row_select` = 12 → `arena_columns` = 0, write ignored.
- Assert reset mid-SCAN at row 4 → `scan_valid` = 0, FSM IDLE, all rows 0.
